matmul_engine: RTL and testbench

//   Self-sequencing unsigned matrix-multiply engine: C[MxP] = A[MxN] * B[NxP].

---
 rtl/matmul_pkg.sv | 19 +
 rtl/matmul_sp_ram.sv | 27 ++
 rtl/matmul_engine.sv | 173 +++++++++++++++++
 tb/tb_matmul_engine.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared types and sizing helpers for the matmul engine.
package matmul_pkg;

  typedef enum logic [2:0] {IDLE, MAC, DRAIN, WRITE, DONE} state_t;

  // Address/counter width for a given depth, never narrower than one bit.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int acc_w(input int data_width, input int n);
    return 2 * data_width + $clog2(n);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/matmul_sp_ram.sv
// Single write port, single synchronous read port RAM; contents are never cleared.
module matmul_sp_ram
  import matmul_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 64,
  localparam int AW   = addr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Writes past the last word are dropped when DEPTH is not a power of two.
  always_ff @(posedge clk) begin
    if (we && (int'(waddr) < DEPTH)) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/matmul_engine.sv
// Self-sequencing unsigned C = A * B engine with internal A/B/C RAMs.
// Define MATMUL_SAT_EN to saturate read-back results instead of truncating them.
module matmul_engine
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int M          = 8,
  parameter int N          = 8,
  parameter int P          = 8,
  localparam int ACC_W     = acc_w(DATA_WIDTH, N),
  localparam int AW        = addr_w(max2(M * N, N * P)),
  localparam int CAW       = addr_w(M * P),
  localparam int SW        = addr_w(ACC_W)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_valid,
  input  logic                  ld_sel,
  input  logic [AW-1:0]         ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic                  ld_ready,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic                  rd_en,
  input  logic [CAW-1:0]        rd_addr,
  input  logic [SW-1:0]         shift_cnt,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid
);

  localparam int AAW = addr_w(M * N);
  localparam int BAW = addr_w(N * P);
  localparam int IW  = addr_w(M);
  localparam int JW  = addr_w(P);
  localparam int KW  = addr_w(N);

  state_t state, state_nxt;

  logic [IW-1:0]           i;
  logic [JW-1:0]           j;
  logic [KW-1:0]           k;
  logic [AAW-1:0]          a_ptr, a_row;
  logic [BAW-1:0]          b_ptr;
  logic [CAW-1:0]          c_ptr;
  logic [ACC_W-1:0]        acc;
  logic                    prod_vld;
  logic [DATA_WIDTH-1:0]   a_q, b_q;
  logic [ACC_W-1:0]        c_q;
  logic [2*DATA_WIDTH-1:0] product;
  logic [SW-1:0]           shift_q;
  logic [DATA_WIDTH-1:0]   narrowed;
  logic                    last_k, last_elem, a_we, b_we, c_we;

  assign busy      = (state == MAC) || (state == DRAIN) || (state == WRITE);
  assign ld_ready  = !busy;
  assign last_k    = (k == KW'(N - 1));
  assign last_elem = (i == IW'(M - 1)) && (j == JW'(P - 1));
  assign a_we      = ld_valid && !busy && !ld_sel && (int'(ld_addr) < M * N);
  assign b_we      = ld_valid && !busy &&  ld_sel && (int'(ld_addr) < N * P);
  assign c_we      = (state == WRITE);
  assign product   = {{DATA_WIDTH{1'b0}}, a_q} * {{DATA_WIDTH{1'b0}}, b_q};

  matmul_sp_ram #(.W(DATA_WIDTH), .DEPTH(M * N)) u_ram_a (
    .clk(clk), .we(a_we), .waddr(ld_addr[AAW-1:0]), .wdata(ld_data),
    .raddr(a_ptr), .rdata(a_q)
  );

  matmul_sp_ram #(.W(DATA_WIDTH), .DEPTH(N * P)) u_ram_b (
    .clk(clk), .we(b_we), .waddr(ld_addr[BAW-1:0]), .wdata(ld_data),
    .raddr(b_ptr), .rdata(b_q)
  );

  matmul_sp_ram #(.W(ACC_W), .DEPTH(M * P)) u_ram_c (
    .clk(clk), .we(c_we), .waddr(c_ptr), .wdata(acc),
    .raddr(rd_addr), .rdata(c_q)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = MAC;
      MAC:     if (last_k) state_nxt = DRAIN;
      DRAIN:   state_nxt = WRITE;
      WRITE:   state_nxt = last_elem ? DONE : MAC;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pointers walk A along a row and B down a column; the RAM read issued in
  // MAC lands a cycle later, hence the delayed prod_vld. done is registered
  // off the DONE state so it appears in the cycle after DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      i        <= '0;
      j        <= '0;
      k        <= '0;
      a_ptr    <= '0;
      a_row    <= '0;
      b_ptr    <= '0;
      c_ptr    <= '0;
      acc      <= '0;
      prod_vld <= 1'b0;
      done     <= 1'b0;
    end else begin
      done     <= (state == DONE);
      prod_vld <= (state == MAC);
      if (prod_vld) acc <= acc + ACC_W'(product);
      case (state)
        IDLE: begin
          if (start) begin
            i     <= '0;
            j     <= '0;
            k     <= '0;
            a_ptr <= '0;
            a_row <= '0;
            b_ptr <= '0;
            c_ptr <= '0;
            acc   <= '0;
          end
        end
        MAC: begin
          a_ptr <= a_ptr + AAW'(1);
          b_ptr <= b_ptr + BAW'(P);
          k     <= k + KW'(1);
        end
        WRITE: begin
          acc   <= '0;
          k     <= '0;
          c_ptr <= c_ptr + CAW'(1);
          if (j == JW'(P - 1)) begin
            j     <= '0;
            i     <= i + IW'(1);
            a_row <= a_ptr;
            b_ptr <= '0;
          end else begin
            j     <= j + JW'(1);
            a_ptr <= a_row;
            b_ptr <= BAW'(j) + BAW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      shift_q  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) shift_q <= shift_cnt;
    end
  end

`ifdef MATMUL_SAT_EN
  logic [ACC_W-1:0] shifted;
  assign shifted  = c_q >> shift_q;
  assign narrowed = (|shifted[ACC_W-1:DATA_WIDTH]) ? '1 : shifted[DATA_WIDTH-1:0];
`else
  assign narrowed = DATA_WIDTH'(c_q >> shift_q);
`endif

  assign rd_data = rd_valid ? narrowed : '0;

endmodule

// File: tb/tb_matmul_engine.sv
// Directed scoreboard bench for matmul_engine: loads, timed runs, and read-back.
module tb_matmul_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       ld_valid, ld_sel, ld_ready;
  logic [5:0] ld_addr;
  logic [7:0] ld_data;
  logic       start, busy, done;
  logic       rd_en, rd_valid;
  logic [5:0] rd_addr;
  logic [4:0] shift_cnt;
  logic [7:0] rd_data;

  int total = 0;
  int bad   = 0;
  int a_m [64];
  int b_m [64];
  int c_m [64];
  int exp_q [$];
  int cyc;

  matmul_engine dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_ready(ld_ready), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .shift_cnt(shift_cnt),
    .rd_data(rd_data), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int narrow(input int c, input int sh);
    int s;
    s = c >> sh;
`ifdef MATMUL_SAT_EN
    return (s > 255) ? 255 : s;
`else
    return s & 255;
`endif
  endfunction

  function automatic void compute_c();
    for (int r = 0; r < 8; r++)
      for (int col = 0; col < 8; col++) begin
        c_m[r*8+col] = 0;
        for (int x = 0; x < 8; x++) c_m[r*8+col] += a_m[r*8+x] * b_m[x*8+col];
      end
  endfunction

  // Back-to-back writes, one per cycle; the caller ends the burst with release_load.
  task automatic apply_stimulus(input logic sel, input int addr, input int data);
    @(negedge clk);
    ld_valid = 1'b1;
    ld_sel   = sel;
    ld_addr  = 6'(addr);
    ld_data  = 8'(data);
    if (sel) b_m[addr] = data;
    else     a_m[addr] = data;
  endtask

  task automatic release_load();
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  task automatic kick();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(inout int n);
    while (done !== 1'b1 && n < 2000) begin
      @(posedge clk);
      #1 n++;
    end
  endtask

  task automatic read_all(input int sh);
    for (int a = 0; a < 64; a++) begin
      @(negedge clk);
      rd_en     = 1'b1;
      rd_addr   = 6'(a);
      shift_cnt = 5'(sh);
      exp_q.push_back(narrow(c_m[a], sh));
    end
    @(negedge clk);
    rd_en = 1'b0;
    repeat (2) @(negedge clk);
    check_output("rd_drain", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("[TB] FAIL rd_unexpected observed=valid expected=idle");
      end else begin
        check_output("rd_data", rd_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1; ld_valid = 0; ld_sel = 0; ld_addr = 0; ld_data = 0;
    start = 0; rd_en = 0; rd_addr = 0; shift_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_busy", busy, 0);
    check_output("rst_done", done, 0);
    check_output("rst_rd_valid", rd_valid, 0);
    check_output("rst_rd_data", rd_data, 0);
    check_output("rst_ld_ready", ld_ready, 1);
    rst = 1'b0;

    $display("[TB] identity times ramp");
    for (int x = 0; x < 64; x++) apply_stimulus(1'b0, x, (x / 8 == x % 8) ? 1 : 0);
    for (int x = 0; x < 64; x++) apply_stimulus(1'b1, x, x);
    release_load();
    compute_c();
    kick();
    cyc = 0;
    check_output("t1_busy", busy, 1);
    wait_done(cyc);
    check_output("t1_done_cycle", cyc, 641);
    @(posedge clk); #1;
    check_output("t1_done_pulse", done, 0);
    check_output("t1_idle_busy", busy, 0);
    read_all(0);

    $display("[TB] all 255");
    for (int x = 0; x < 64; x++) apply_stimulus(1'b0, x, 255);
    for (int x = 0; x < 64; x++) apply_stimulus(1'b1, x, 255);
    release_load();
    compute_c();
    kick();
    cyc = 0;
    wait_done(cyc);
    check_output("t2_done_cycle", cyc, 641);
    read_all(11);
    read_all(0);

    $display("[TB] start and load while busy");
    kick();
    cyc = 0;
    repeat (50) begin @(posedge clk); #1 cyc++; end
    check_output("t3_ld_ready", ld_ready, 0);
    start = 1'b1; ld_valid = 1'b1; ld_sel = 1'b0; ld_addr = 6'd0; ld_data = 8'd0;
    @(posedge clk);
    #1 cyc++;
    start = 1'b0; ld_valid = 1'b0;
    wait_done(cyc);
    check_output("t3_done_cycle", cyc, 641);
    read_all(11);

    $display("[TB] reset mid-run");
    for (int x = 0; x < 64; x++) apply_stimulus(1'b0, x, (x / 8 == x % 8) ? 1 : 0);
    for (int x = 0; x < 64; x++) apply_stimulus(1'b1, x, int'($urandom_range(0, 255)));
    release_load();
    compute_c();
    kick();
    repeat (99) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check_output("t4_busy", busy, 0);
    check_output("t4_done", done, 0);
    rst = 1'b0;
    kick();
    cyc = 0;
    wait_done(cyc);
    check_output("t4_done_cycle", cyc, 641);
    read_all(0);

    $display("[TB] load and start together");
    @(negedge clk);
    ld_valid = 1'b1; ld_sel = 1'b0; ld_addr = 6'd0; ld_data = 8'd3; start = 1'b1;
    a_m[0] = 3;
    @(posedge clk);
    #1 ld_valid = 1'b0; start = 1'b0;
    compute_c();
    cyc = 0;
    check_output("t5_busy", busy, 1);
    wait_done(cyc);
    check_output("t5_done_cycle", cyc, 641);
    read_all(0);

    $display("[TB] start held across done");
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    cyc = 0;
    wait_done(cyc);
    check_output("t6_done_cycle", cyc, 641);
    @(posedge clk); #1;
    check_output("t6_done_pulse", done, 0);
    check_output("t6_restart_busy", busy, 1);
    start = 1'b0;
    cyc = 0;
    wait_done(cyc);
    check_output("t6_second_done_cycle", cyc, 641);
    @(posedge clk); #1;
    check_output("t6_final_done", done, 0);
    check_output("t6_final_busy", busy, 0);
    read_all(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
